mem_responder: RTL

- Memory-side responder for the 9-bit processor datapath.
- Accepts the registered address (ADDR), write data (DOUT) and write strobe (W) from the processor, and returns read data on DIN.
- Owns a synchronous 128-word RAM, memory-mapped LED/HEX output registers and a switch input port.
- Contains a program-loader state machine that fills the RAM after reset, then releases the processor via run.

---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/sync_ram_rf.sv | 31 +++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder.
// Contents: loader state type, address-region codes (addr[8:7]),
// default data width and RAM depth.
package mem_responder_pkg;

  localparam int DW_DEF    = 9;
  localparam int DEPTH_DEF = 128;

  typedef enum logic {LOAD, RUN} ld_state_t;

  localparam logic [1:0] REG_RAM = 2'b00;
  localparam logic [1:0] REG_LED = 2'b01;
  localparam logic [1:0] REG_HEX = 2'b10;
  localparam logic [1:0] REG_SW  = 2'b11;

endpackage

// File: rtl/sync_ram_rf.sv
// Single-port synchronous RAM, read-first, DEPTH x DW.
// Ports:
//   clk    - clock
//   we     - write enable
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data (old contents on a same-address write)
// Contents are deliberately not reset.
module sync_ram_rf #(
  parameter int DW    = 9,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 9-bit processor datapath.
// Owns a 128-word RAM, LED/HEX output registers and a switch input port,
// plus a program loader that fills RAM after reset before releasing the
// processor through run.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   addr, wdata, we     - processor address / write data / write strobe
//   rdata               - read data, one cycle after addr is sampled
//   run                 - processor run enable
//   ld_valid, ld_data   - loader word stream
//   ld_last, ld_skip    - loader end marker / bypass loading
//   ld_ptr              - next loader write index
//   sw                  - switch inputs
//   led, hex            - output registers
//
// Build option: define SW_SYNC_EN to pass sw through a two-flop synchronizer
// before it is read (adds two cycles of switch latency).
//
// state | meaning
// LOAD  | loader owns the RAM port; processor ignored, rdata held at 0
// RUN   | processor owns the RAM port; terminal until reset
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int            DW      = DW_DEF,
  parameter int            DEPTH   = DEPTH_DEF,
  parameter logic [DW-1:0] LED_RST = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            addr,
  input  logic [DW-1:0]            wdata,
  input  logic                     we,
  output logic [DW-1:0]            rdata,
  output logic                     run,
  input  logic                     ld_valid,
  input  logic [DW-1:0]            ld_data,
  input  logic                     ld_last,
  input  logic                     ld_skip,
  output logic [$clog2(DEPTH)-1:0] ld_ptr,
  input  logic [DW-1:0]            sw,
  output logic [DW-1:0]            led,
  output logic [DW-1:0]            hex
);

  localparam int AW = $clog2(DEPTH);

  ld_state_t     state_q;
  logic [AW-1:0] ptr_q;
  logic          run_q;
  logic          rd_en_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] reg_rd_q;
  logic [DW-1:0] led_q;
  logic [DW-1:0] hex_q;

  logic [1:0]    region;
  logic          in_run;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] sw_v;

  assign region = addr[DW-1:DW-2];
  assign in_run = (state_q == RUN);

`ifdef SW_SYNC_EN
  logic [DW-1:0] sw_s1_q;
  logic [DW-1:0] sw_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  assign sw_v = sw_s2_q;
`else
  assign sw_v = sw;
`endif

  // RAM port ownership follows the loader state.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ptr_q;
    ram_wdata = ld_data;
    if (in_run) begin
      ram_we    = we && (region == REG_RAM);
      ram_addr  = addr[AW-1:0];
      ram_wdata = wdata;
    end else begin
      ram_we    = ld_valid && !ld_skip;
    end
  end

  sync_ram_rf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Loader FSM; run is a registered copy of the state, one cycle behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= (state_q == RUN);
      case (state_q)
        LOAD: begin
          if (ld_skip) begin
            state_q <= RUN;
          end else if (ld_valid) begin
            ptr_q <= ptr_q + 1'b1;
            if (ld_last || (ptr_q == AW'(DEPTH - 1))) state_q <= RUN;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= LOAD;
      endcase
    end
  end

  // Register reads capture the pre-edge value, matching the RAM's read-first
  // behaviour when a write lands on the address being read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q  <= 1'b0;
      sel_q    <= REG_RAM;
      reg_rd_q <= '0;
      led_q    <= LED_RST;
      hex_q    <= '0;
    end else begin
      rd_en_q <= in_run;
      sel_q   <= region;
      case (region)
        REG_LED: reg_rd_q <= led_q;
        REG_HEX: reg_rd_q <= hex_q;
        REG_SW:  reg_rd_q <= sw_v;
        default: reg_rd_q <= '0;
      endcase
      if (in_run && we) begin
        if (region == REG_LED) led_q <= wdata;
        if (region == REG_HEX) hex_q <= wdata;
      end
    end
  end

  assign rdata  = !rd_en_q ? '0 : ((sel_q == REG_RAM) ? ram_rdata : reg_rd_q);
  assign run    = run_q;
  assign ld_ptr = ptr_q;
  assign led    = led_q;
  assign hex    = hex_q;

endmodule
